wqi_defuzzifier: RTL and testbench

//  Centroid defuzzifier that consumes the output-fuzzy-set IDs (1..7) produced by the rule base, each paired with
//  a firing strength. Accumulates one frame of weighted terms and divides to a crisp Water Quality Index (WQI, 0..100).

---
 rtl/wqi_fuzzy_pkg.sv | 45 ++++
 rtl/wqi_seq_divider.sv | 81 ++++++++
 rtl/wqi_defuzzifier.sv | 207 ++++++++++++++++++++
 tb/tb_wqi_defuzzifier.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wqi_fuzzy_pkg.sv
// Shared definitions for the Water Quality Index defuzzifier.
//   SET_ID_1..SET_ID_7 : legal output fuzzy set IDs
//   WQI_MAX            : largest crisp index the block can produce
//   state_t            : top-level FSM states
//   centroid()         : set ID -> crisp centroid on the 0..100 scale
//   id_legal()         : true for IDs 1..7
package wqi_fuzzy_pkg;

   localparam logic [7:0] SET_ID_1 = 8'd1;
   localparam logic [7:0] SET_ID_2 = 8'd2;
   localparam logic [7:0] SET_ID_3 = 8'd3;
   localparam logic [7:0] SET_ID_4 = 8'd4;
   localparam logic [7:0] SET_ID_5 = 8'd5;
   localparam logic [7:0] SET_ID_6 = 8'd6;
   localparam logic [7:0] SET_ID_7 = 8'd7;

   localparam int WQI_MAX = 100;

   typedef enum logic [1:0] {
      S_ACCUM = 2'd0,
      S_ROUND = 2'd1,
      S_DIV   = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   function automatic logic [6:0] centroid(input logic [7:0] id);
      logic [6:0] c;
      case (id)
         SET_ID_1: c = 7'd0;
         SET_ID_2: c = 7'd17;
         SET_ID_3: c = 7'd33;
         SET_ID_4: c = 7'd50;
         SET_ID_5: c = 7'd67;
         SET_ID_6: c = 7'd83;
         SET_ID_7: c = 7'd100;
         default:  c = 7'd0;
      endcase
      return c;
   endfunction

   function automatic logic id_legal(input logic [7:0] id);
      return (id >= SET_ID_1) && (id <= SET_ID_7);
   endfunction

endpackage

// File: rtl/wqi_seq_divider.sv
// Sequential restoring divider producing a 7-bit quotient, one bit per cycle.
// The caller guarantees the quotient fits in 7 bits.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : load dividend/divisor and begin (ignored unless idle)
//   rem_i        : dividend (already rounding-biased by the caller)
//   den_i        : divisor, must be non-zero
//   busy_o       : iterations in progress
//   done_o       : high during the final iteration cycle
//   quot_o       : quotient, held until the next start
module wqi_seq_divider #(
   parameter int NUM_W = 24,
   parameter int DEN_W = 17
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [NUM_W:0]   rem_i,
   input  logic [DEN_W-1:0] den_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [6:0]       quot_o
);

   // Wide enough for both the dividend and the divisor shifted left by 6.
   localparam int CW = ((NUM_W + 1) > (DEN_W + 7)) ? (NUM_W + 1) : (DEN_W + 7);

   logic          busy_q, busy_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [CW-1:0] rem_q, rem_d;
   logic [CW-1:0] den_q, den_d;
   logic [6:0]    quot_q, quot_d;
   logic [CW-1:0] trial;

   always_comb begin
      trial  = den_q << cnt_q;
      busy_d = busy_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      den_d  = den_q;
      quot_d = quot_q;
      if (start_i && !busy_q) begin
         rem_d  = CW'(rem_i);
         den_d  = CW'(den_i);
         cnt_d  = 3'd6;
         busy_d = 1'b1;
         quot_d = 7'd0;
      end else if (busy_q) begin
         if (rem_q >= trial) begin
            rem_d         = rem_q - trial;
            quot_d[cnt_q] = 1'b1;
         end
         if (cnt_q == 3'd0) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 3'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
         cnt_q  <= 3'd0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // Datapath registers carry no reset; they are only read after a start.
   always_ff @(posedge clk_i) begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      quot_q <= quot_d;
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == 3'd0);
   assign quot_o = quot_q;

endmodule

// File: rtl/wqi_defuzzifier.sv
// Centroid defuzzifier: accumulates one frame of (set ID, firing strength)
// terms and divides sum(mu*centroid) by sum(mu) into a crisp WQI 0..100.
// Optional feature macro: WQI_DOMINANT_SET_EN adds DOMINANT_SET_ID.
//   CLK, RST             : clock, synchronous active-high reset
//   IN_VALID/IN_READY    : term handshake (ready only while accumulating)
//   OUTPUT_FUZZY_SET_ID  : set ID of the term, 1..7 legal
//   MEMBERSHIP           : firing strength of the term
//   IN_LAST              : final term of the frame
//   OUT_VALID/OUT_READY  : result handshake
//   WQI                  : crisp index
//   ZERO_FLAG            : frame had zero total strength, WQI forced to 0
//   ERR_FLAG             : frame contained an illegal ID
//   OVF_FLAG             : an accumulator would have overflowed
//   DOMINANT_SET_ID      : strongest legal accepted set (WQI_DOMINANT_SET_EN)
module wqi_defuzzifier
   import wqi_fuzzy_pkg::*;
#(
   parameter int MU_W  = 8,
   parameter int NUM_W = 24,
   parameter int DEN_W = 17
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [7:0]      OUTPUT_FUZZY_SET_ID,
   input  logic [MU_W-1:0] MEMBERSHIP,
   input  logic            IN_LAST,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [6:0]      WQI,
   output logic            ZERO_FLAG,
   output logic            ERR_FLAG,
   output logic            OVF_FLAG
`ifdef WQI_DOMINANT_SET_EN
   ,
   output logic [7:0]      DOMINANT_SET_ID
`endif
);

   state_t            state_q, state_d;
   logic [NUM_W-1:0]  num_q, num_d;
   logic [DEN_W-1:0]  den_q, den_d;
   logic              err_q, err_d;
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;

   logic              take;
   logic              legal;
   logic [MU_W+6:0]   term_prod;
   logic [NUM_W:0]    num_sum;
   logic [DEN_W:0]    den_sum;
   logic [NUM_W:0]    rem_round;

   logic              div_start;
   logic              div_busy;
   logic              div_done;
   logic [6:0]        div_quot;

`ifdef WQI_DOMINANT_SET_EN
   logic [7:0]        dom_id_q, dom_id_d;
   logic [MU_W-1:0]   dom_mu_q, dom_mu_d;
   logic              dom_vld_q, dom_vld_d;
`endif

   assign take      = IN_VALID && IN_READY;
   assign legal     = id_legal(OUTPUT_FUZZY_SET_ID);
   assign term_prod = (MU_W+7)'(MEMBERSHIP) * (MU_W+7)'(centroid(OUTPUT_FUZZY_SET_ID));
   // One extra bit on each sum exposes the carry used as the overflow test.
   assign num_sum   = (NUM_W+1)'(num_q) + (NUM_W+1)'(term_prod);
   assign den_sum   = (DEN_W+1)'(den_q) + (DEN_W+1)'(MEMBERSHIP);
   // Adding half the divisor turns the truncating divide into round-half-up.
   assign rem_round = (NUM_W+1)'(num_q) + (NUM_W+1)'(den_q >> 1);

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ACCUM: if (take && IN_LAST) state_d = S_ROUND;
         S_ROUND: state_d = (den_q == '0) ? S_OUT : S_DIV;
         S_DIV:   if (div_done) state_d = S_OUT;
         S_OUT:   if (OUT_READY) state_d = S_ACCUM;
         default: state_d = S_ACCUM;
      endcase
   end

   // Outputs
   always_comb begin
      IN_READY  = (state_q == S_ACCUM) && !RST;
      OUT_VALID = (state_q == S_OUT);
      div_start = (state_q == S_ROUND) && (den_q != '0) && !div_busy;
      WQI       = ((state_q == S_OUT) && !zero_q) ? div_quot : 7'd0;
      ZERO_FLAG = zero_q;
      ERR_FLAG  = err_q;
      OVF_FLAG  = ovf_q;
`ifdef WQI_DOMINANT_SET_EN
      DOMINANT_SET_ID = dom_id_q;
`endif
   end

   // Accumulator and flag next-state
   always_comb begin
      num_d  = num_q;
      den_d  = den_q;
      err_d  = err_q;
      ovf_d  = ovf_q;
      zero_d = zero_q;
`ifdef WQI_DOMINANT_SET_EN
      dom_id_d  = dom_id_q;
      dom_mu_d  = dom_mu_q;
      dom_vld_d = dom_vld_q;
`endif
      case (state_q)
         S_ACCUM: begin
            if (take) begin
               if (!legal) begin
                  err_d = 1'b1;
               end else if (!ovf_q) begin
                  // Once a sum would overflow, the rest of the frame is dropped.
                  if (num_sum[NUM_W] || den_sum[DEN_W]) begin
                     ovf_d = 1'b1;
                  end else begin
                     num_d = num_sum[NUM_W-1:0];
                     den_d = den_sum[DEN_W-1:0];
`ifdef WQI_DOMINANT_SET_EN
                     if (!dom_vld_q || (MEMBERSHIP > dom_mu_q) ||
                         ((MEMBERSHIP == dom_mu_q) && (OUTPUT_FUZZY_SET_ID < dom_id_q))) begin
                        dom_id_d  = OUTPUT_FUZZY_SET_ID;
                        dom_mu_d  = MEMBERSHIP;
                        dom_vld_d = 1'b1;
                     end
`endif
                  end
               end
            end
         end
         S_ROUND: begin
            if (den_q == '0) zero_d = 1'b1;
         end
         S_OUT: begin
            if (OUT_READY) begin
               num_d  = '0;
               den_d  = '0;
               err_d  = 1'b0;
               ovf_d  = 1'b0;
               zero_d = 1'b0;
`ifdef WQI_DOMINANT_SET_EN
               dom_id_d  = 8'd0;
               dom_mu_d  = '0;
               dom_vld_d = 1'b0;
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         num_q  <= '0;
         den_q  <= '0;
         err_q  <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
`ifdef WQI_DOMINANT_SET_EN
         dom_id_q  <= 8'd0;
         dom_mu_q  <= '0;
         dom_vld_q <= 1'b0;
`endif
      end else begin
         num_q  <= num_d;
         den_q  <= den_d;
         err_q  <= err_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
`ifdef WQI_DOMINANT_SET_EN
         dom_id_q  <= dom_id_d;
         dom_mu_q  <= dom_mu_d;
         dom_vld_q <= dom_vld_d;
`endif
      end
   end

   wqi_seq_divider #(
      .NUM_W (NUM_W),
      .DEN_W (DEN_W)
   ) u_div (
      .clk_i   (CLK),
      .rst_i   (RST),
      .start_i (div_start),
      .rem_i   (rem_round),
      .den_i   (den_q),
      .busy_o  (div_busy),
      .done_o  (div_done),
      .quot_o  (div_quot)
   );

endmodule

// File: tb/tb_wqi_defuzzifier.sv
// Self-checking bench for wqi_defuzzifier: directed frames, back-pressure,
// reset mid-frame / mid-division, accumulator overflow and random frames
// against a behavioural centroid model.
module tb_wqi_defuzzifier;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       IN_VALID = 1'b0;
   logic       IN_READY;
   logic [7:0] ID = 8'd0;
   logic [7:0] MU = 8'd0;
   logic       IN_LAST = 1'b0;
   logic       OUT_VALID;
   logic       OUT_READY = 1'b0;
   logic [6:0] WQI;
   logic       ZERO_FLAG, ERR_FLAG, OVF_FLAG;
`ifdef WQI_DOMINANT_SET_EN
   logic [7:0] DOM;
`endif

   int total = 0;
   int bad   = 0;
   int q_id[$];
   int q_mu[$];
   int gap_max = 0;
   int cent [0:7] = '{0, 0, 17, 33, 50, 67, 83, 100};

   always #5 CLK = ~CLK;

   wqi_defuzzifier dut (
      .CLK                 (CLK),
      .RST                 (RST),
      .IN_VALID            (IN_VALID),
      .IN_READY            (IN_READY),
      .OUTPUT_FUZZY_SET_ID (ID),
      .MEMBERSHIP          (MU),
      .IN_LAST             (IN_LAST),
      .OUT_VALID           (OUT_VALID),
      .OUT_READY           (OUT_READY),
      .WQI                 (WQI),
      .ZERO_FLAG           (ZERO_FLAG),
      .ERR_FLAG            (ERR_FLAG),
      .OVF_FLAG            (OVF_FLAG)
`ifdef WQI_DOMINANT_SET_EN
      ,
      .DOMINANT_SET_ID     (DOM)
`endif
   );

   // Centroid reference: weighted mean of centroids, rounded half up.
   task automatic model(output int w, output int z, output int e, output int o,
                        output int dom, output int lat);
      longint num = 0;
      longint den = 0;
      int best = -1;
      w = 0; z = 0; e = 0; o = 0; dom = 0;
      foreach (q_id[i]) begin
         if (q_id[i] < 1 || q_id[i] > 7) begin
            e = 1;
         end else if (o == 0) begin
            if (num + q_mu[i] * cent[q_id[i]] > 64'd16777215 || den + q_mu[i] > 64'd131071) begin
               o = 1;
            end else begin
               num += q_mu[i] * cent[q_id[i]];
               den += q_mu[i];
               if (q_mu[i] > best || (q_mu[i] == best && q_id[i] < dom)) begin
                  best = q_mu[i];
                  dom  = q_id[i];
               end
            end
         end
      end
      if (den == 0) begin
         z = 1; lat = 2;
      end else begin
         w = int'((2 * num + den) / (2 * den)); lat = 9;
      end
   endtask

   // Sends the queued frame; returns cycles from LAST acceptance to OUT_VALID (-1 on timeout).
   task automatic send_frame(output int lat);
      int n = q_id.size();
      int c = 0;
      lat = -1;
      for (int i = 0; i < n; i++) begin
         int g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         int wt = 0;
         repeat (g) begin
            @(negedge CLK); IN_VALID = 1'b0;
            @(posedge CLK);
         end
         @(negedge CLK);
         IN_VALID = 1'b1; ID = 8'(q_id[i]); MU = 8'(q_mu[i]); IN_LAST = (i == n - 1);
         while (!IN_READY && wt < 50) begin
            @(negedge CLK); wt++;
         end
         if (wt >= 50) begin
            IN_VALID = 1'b0;
            return;
         end
         @(posedge CLK);
      end
      do begin
         @(negedge CLK); c++;
         if (c == 1) begin IN_VALID = 1'b0; IN_LAST = 1'b0; end
      end while (!OUT_VALID && c < 40);
      if (OUT_VALID) lat = c;
   endtask

   task automatic accept_result();
      OUT_READY = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      OUT_READY = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b want 0", IN_READY); end
      total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", OUT_VALID); end
      total++; if (WQI !== 7'd0) begin bad++; $display("FAIL reset_wqi: got %0d want 0", WQI); end
      total++; if ({ZERO_FLAG, ERR_FLAG, OVF_FLAG} !== 3'b000) begin bad++;
         $display("FAIL reset_flags: got %b want 000", {ZERO_FLAG, ERR_FLAG, OVF_FLAG}); end
      RST = 1'b0;
      @(negedge CLK);
      total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %0b want 1", IN_READY); end
   endtask

   task automatic test_directed();
      // id0,mu0,id1,mu1,len,wqi,zero,err,lat
      int tbl [0:5][0:8] = '{
         '{4, 255, 0, 0,   1, 50, 0, 0, 9},
         '{1, 100, 7, 100, 2, 50, 0, 0, 9},
         '{2, 200, 3, 100, 2, 22, 0, 0, 9},
         '{9, 50,  5, 10,  2, 67, 0, 1, 9},
         '{6, 0,   0, 0,   1, 0,  1, 0, 2},
         '{1, 255, 0, 0,   1, 0,  0, 0, 9}};
      for (int k = 0; k < 6; k++) begin
         int lat, mw, mz, me, mo, md, ml;
         q_id.delete(); q_mu.delete();
         q_id.push_back(tbl[k][0]); q_mu.push_back(tbl[k][1]);
         if (tbl[k][4] == 2) begin q_id.push_back(tbl[k][2]); q_mu.push_back(tbl[k][3]); end
         model(mw, mz, me, mo, md, ml);
         send_frame(lat);
         total++; if (lat !== tbl[k][8]) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", k, lat, tbl[k][8]); end
         total++; if (int'(WQI) !== tbl[k][5]) begin bad++; $display("FAIL dir%0d_wqi: got %0d want %0d", k, WQI, tbl[k][5]); end
         total++; if ({ZERO_FLAG, ERR_FLAG, OVF_FLAG} !== {tbl[k][6][0], tbl[k][7][0], 1'b0}) begin bad++;
            $display("FAIL dir%0d_flags: got %b want %b%b0", k, {ZERO_FLAG, ERR_FLAG, OVF_FLAG}, tbl[k][6][0], tbl[k][7][0]); end
`ifdef WQI_DOMINANT_SET_EN
         total++; if (int'(DOM) !== md) begin bad++; $display("FAIL dir%0d_dom: got %0d want %0d", k, DOM, md); end
`endif
         accept_result();
      end
   endtask

   task automatic test_hold();
      int lat;
      int ok = 1;
      q_id = '{2, 3}; q_mu = '{200, 100};
      send_frame(lat);
      repeat (5) begin
         @(negedge CLK);
         if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || WQI !== 7'd22 ||
             {ZERO_FLAG, ERR_FLAG, OVF_FLAG} !== 3'b000) ok = 0;
      end
      total++; if (ok != 1) begin bad++; $display("FAIL hold_stable: got wqi=%0d vld=%0b rdy=%0b want 22/1/0", WQI, OUT_VALID, IN_READY); end
      accept_result();
      total++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin bad++;
         $display("FAIL handoff: got vld=%0b rdy=%0b want 0/1", OUT_VALID, IN_READY); end
   endtask

   task automatic test_reset_midframe();
      int lat;
      int seen = 0;
      @(negedge CLK); IN_VALID = 1'b1; ID = 8'd1; MU = 8'd200; IN_LAST = 1'b0;
      @(posedge CLK);
      @(negedge CLK); ID = 8'd2; MU = 8'd100;
      @(posedge CLK);
      @(negedge CLK); IN_VALID = 1'b0; RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      total++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0) begin bad++;
         $display("FAIL rst_mid_outputs: got rdy=%0b vld=%0b want 0/0", IN_READY, OUT_VALID); end
      RST = 1'b0;
      q_id = '{7}; q_mu = '{1};
      send_frame(lat);
      total++; if (WQI !== 7'd100 || lat !== 9) begin bad++; $display("FAIL rst_mid_frame: got wqi=%0d lat=%0d want 100/9", WQI, lat); end
      accept_result();
      // Reset in the middle of a division must drop the result entirely.
      @(negedge CLK); IN_VALID = 1'b1; ID = 8'd4; MU = 8'd255; IN_LAST = 1'b1;
      @(posedge CLK);
      @(negedge CLK); IN_VALID = 1'b0; IN_LAST = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK); RST = 1'b0;
      repeat (12) begin @(negedge CLK); if (OUT_VALID) seen = 1; end
      total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_div: got out_valid=1 want 0"); end
      q_id = '{5}; q_mu = '{10};
      send_frame(lat);
      total++; if (WQI !== 7'd67 || lat !== 9) begin bad++; $display("FAIL after_rst_div: got wqi=%0d lat=%0d want 67/9", WQI, lat); end
      accept_result();
   endtask

   task automatic test_overflow();
      int lat;
      q_id.delete(); q_mu.delete();
      repeat (515) begin q_id.push_back(7); q_mu.push_back(255); end
      q_id.push_back(1); q_mu.push_back(255);
      send_frame(lat);
      total++; if (WQI !== 7'd100 || OVF_FLAG !== 1'b1 || ERR_FLAG !== 1'b0 || ZERO_FLAG !== 1'b0) begin bad++;
         $display("FAIL overflow: got wqi=%0d ovf=%0b err=%0b zero=%0b want 100/1/0/0", WQI, OVF_FLAG, ERR_FLAG, ZERO_FLAG); end
      total++; if (lat !== 9) begin bad++; $display("FAIL overflow_latency: got %0d want 9", lat); end
      accept_result();
   endtask

`ifdef WQI_DOMINANT_SET_EN
   task automatic test_dominant();
      int lat;
      q_id = '{3, 5}; q_mu = '{80, 80};
      send_frame(lat);
      total++; if (DOM !== 8'd3) begin bad++; $display("FAIL dominant_tie: got %0d want 3", DOM); end
      accept_result();
   endtask
`endif

   task automatic test_random();
      gap_max = 2;
      for (int f = 0; f < 40; f++) begin
         int len = int'($urandom_range(6, 1));
         int lat, mw, mz, me, mo, md, ml, h;
         int ok = 1;
         logic [6:0] w0;
         q_id.delete(); q_mu.delete();
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(9, 0) == 0) q_id.push_back(($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, 8)));
            else q_id.push_back(int'($urandom_range(7, 1)));
            q_mu.push_back(($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(255, 0)));
         end
         model(mw, mz, me, mo, md, ml);
         send_frame(lat);
         total++; if (lat !== ml) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", f, lat, ml); end
         total++; if (int'(WQI) !== mw) begin bad++; $display("FAIL rnd%0d_wqi: got %0d want %0d", f, WQI, mw); end
         total++; if ({ZERO_FLAG, ERR_FLAG, OVF_FLAG} !== {mz[0], me[0], mo[0]}) begin bad++;
            $display("FAIL rnd%0d_flags: got %b want %b%b%b", f, {ZERO_FLAG, ERR_FLAG, OVF_FLAG}, mz[0], me[0], mo[0]); end
`ifdef WQI_DOMINANT_SET_EN
         total++; if (int'(DOM) !== md) begin bad++; $display("FAIL rnd%0d_dom: got %0d want %0d", f, DOM, md); end
`endif
         w0 = WQI;
         h = int'($urandom_range(3, 0));
         repeat (h) begin @(negedge CLK); if (OUT_VALID !== 1'b1 || WQI !== w0) ok = 0; end
         total++; if (ok != 1) begin bad++; $display("FAIL rnd%0d_hold: got wqi=%0d vld=%0b want %0d/1", f, WQI, OUT_VALID, w0); end
         accept_result();
      end
      gap_max = 0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_reset_midframe();
      test_overflow();
`ifdef WQI_DOMINANT_SET_EN
      test_dominant();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
